// File: rtl/nfa_stream_sched.sv
// nfa_stream_sched: round-robin packet scheduler sharing one byte-serial NFA matcher between
// two byte-stream requesters; reports hit, first-match offset and length per packet.
module nfa_stream_sched #(
    parameter int LEN_W     = 16,
    parameter int MATCH_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s0_valid,
    input  logic [7:0]       s0_data,
    input  logic             s0_last,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [7:0]       s1_data,
    input  logic             s1_last,
    output logic             s1_ready,
    output logic             nfa_en,
    output logic [7:0]       nfa_payload,
    output logic             nfa_clear,
    input  logic             nfa_match,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_src,
    output logic             res_hit,
    output logic [LEN_W-1:0] res_offset,
    output logic [LEN_W-1:0] res_len
);
    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, REPORT, CLEAR} state_t;

    localparam int DW = $clog2(MATCH_LAT + 1);
    localparam logic [DW-1:0] DRAIN_END = DW'(MATCH_LAT);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t state, state_nxt;
    logic last_grant, src, grant, hit, accept, sel_valid, sel_last;
    logic [7:0] sel_data;
    logic [LEN_W-1:0] idx, nfa_idx;
    logic [DW-1:0] drain_cnt;
    logic pipe_en [MATCH_LAT];
    logic [LEN_W-1:0] pipe_idx [MATCH_LAT];

    assign res_src = src;
    assign res_hit = hit;
    assign res_len = idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        grant     = (s0_valid && s1_valid) ? !last_grant : s1_valid;
        sel_valid = src ? s1_valid : s0_valid;
        sel_last  = src ? s1_last : s0_last;
        sel_data  = src ? s1_data : s0_data;
        accept    = state == STREAM && sel_valid;
        s0_ready  = state == STREAM && !src;
        s1_ready  = state == STREAM && src;
        res_valid = state == REPORT;
        state_nxt = state;
        case (state)
            IDLE:    if (s0_valid || s1_valid) state_nxt = STREAM;
            STREAM:  if (accept && sel_last) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_END) state_nxt = REPORT;
            REPORT:  if (res_ready) state_nxt = CLEAR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant  <= 1'b1;
            src         <= 1'b0;
            hit         <= 1'b0;
            idx         <= '0;
            nfa_idx     <= '0;
            res_offset  <= '0;
            nfa_en      <= 1'b0;
            nfa_payload <= '0;
            nfa_clear   <= 1'b0;
            drain_cnt   <= '0;
            for (int i = 0; i < MATCH_LAT; i++) begin
                pipe_en[i]  <= 1'b0;
                pipe_idx[i] <= '0;
            end
        end else begin
            nfa_en      <= accept;
            nfa_clear   <= state == REPORT && res_ready;
            drain_cnt   <= state == DRAIN ? drain_cnt + 1'b1 : '0;
            pipe_en[0]  <= nfa_en;
            pipe_idx[0] <= nfa_idx;
            for (int i = 1; i < MATCH_LAT; i++) begin
                pipe_en[i]  <= pipe_en[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            if (state == IDLE && (s0_valid || s1_valid)) begin
                src        <= grant;
                last_grant <= grant;
            end
            // nfa_idx travels with the byte so the match can be attributed after the latency
            if (accept) begin
                nfa_payload <= sel_data;
                nfa_idx     <= idx;
                idx         <= idx == LEN_MAX ? idx : idx + 1'b1;
            end
            if (state == CLEAR) begin
                idx        <= '0;
                hit        <= 1'b0;
                res_offset <= '0;
            end else if (pipe_en[MATCH_LAT-1] && nfa_match && !hit) begin
                hit        <= 1'b1;
                res_offset <= pipe_idx[MATCH_LAT-1];
            end
        end
    end
endmodule

// File: tb/tb_nfa_stream_sched.sv
// tb_nfa_stream_sched: random and directed packets against a timeline model of the scheduler,
// with a behavioural "abc" matcher standing in for the NFA.
module tb_nfa_stream_sched;
    localparam int L = 1;

    typedef struct packed {logic src; logic hit; logic [15:0] off; logic [15:0] len;} res_t;

    logic clk = 0, reset_n = 1;
    logic s0_valid = 0, s1_valid = 0, s0_last = 0, s1_last = 0, s0_ready, s1_ready;
    logic [7:0] s0_data = 0, s1_data = 0, nfa_payload;
    logic nfa_en, nfa_clear, nfa_match, res_valid, res_ready = 0, res_src, res_hit;
    logic [15:0] res_offset, res_len;

    int total = 0, bad = 0;

    nfa_stream_sched #(.LEN_W(16), .MATCH_LAT(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
        .nfa_en(nfa_en), .nfa_payload(nfa_payload), .nfa_clear(nfa_clear), .nfa_match(nfa_match),
        .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src), .res_hit(res_hit),
        .res_offset(res_offset), .res_len(res_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // "abc" matcher with one cycle of latency, honouring en and clear
    logic [1:0] nst;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nst <= 0;
            nfa_match <= 0;
        end else if (nfa_clear) begin
            nst <= 0;
            nfa_match <= 0;
        end else if (nfa_en) begin
            nfa_match <= nst == 2 && nfa_payload == "c";
            nst <= nfa_payload == "a" ? 2'd1 : (nfa_payload == "b" && nst == 1) ? 2'd2 : 2'd0;
        end
    end

    // Timeline model: 0 idle, 1 streaming, 2 draining, 3 reporting, 4 clearing
    int phase = 0, dl = 0, clr_cnt = 0;
    logic m_src = 0, m_last = 1, m_en = 0, m_clr = 0;
    logic [7:0] m_pay = 0, b;
    logic [7:0] pk[$];
    res_t m_res, got[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            phase = 0; m_last = 1; m_en = 0; m_clr = 0; m_pay = 0; pk.delete();
        end else begin
            chk("s0_ready", s0_ready, phase == 1 && !m_src);
            chk("s1_ready", s1_ready, phase == 1 && m_src);
            chk("nfa_en", nfa_en, m_en);
            chk("nfa_payload", nfa_payload, m_pay);
            chk("nfa_clear", nfa_clear, m_clr);
            chk("res_valid", res_valid, phase == 3);
            if (phase == 3) begin
                chk("res_src", res_src, m_res.src);
                chk("res_hit", res_hit, m_res.hit);
                chk("res_offset", res_offset, m_res.off);
                chk("res_len", res_len, m_res.len);
            end
            if (nfa_clear) clr_cnt++;
            m_en = 0;
            m_clr = 0;
            case (phase)
                0: if (s0_valid || s1_valid) begin
                    m_src = (s0_valid && s1_valid) ? !m_last : s1_valid;
                    m_last = m_src;
                    phase = 1;
                end
                1: if (m_src ? s1_valid : s0_valid) begin
                    b = m_src ? s1_data : s0_data;
                    m_en = 1;
                    m_pay = b;
                    pk.push_back(b);
                    if (m_src ? s1_last : s0_last) begin
                        m_res = '{src: m_src, hit: 1'b0, off: 16'd0, len: 16'(pk.size())};
                        for (int i = 2; i < pk.size(); i++)
                            if (!m_res.hit && pk[i-2] == "a" && pk[i-1] == "b" && pk[i] == "c") begin
                                m_res.hit = 1;
                                m_res.off = 16'(i);
                            end
                        pk.delete();
                        phase = 2;
                        dl = L + 1;
                    end
                end
                2: begin
                    dl--;
                    if (dl == 0) phase = 3;
                end
                3: if (res_ready) begin
                    got.push_back({res_src, res_hit, res_offset, res_len});
                    m_clr = 1;
                    phase = 4;
                end
                default: phase = 0;
            endcase
        end
    end

    // Stimulus: per-source byte queues {last,data}, inter-byte gaps, result back-pressure
    logic [8:0] q0[$], q1[$];
    logic [7:0] al [4] = '{8'h61, 8'h62, 8'h63, 8'h78};
    int g0 = 0, g1 = 0, gap = 0, hold = 0, rv_cnt = 0, acc_n = 0, n0;
    bit rnd_gap = 0, rnd_hold = 0, a0, a1;

    task automatic push(input bit s, input string str);
        logic [8:0] e;
        for (int i = 0; i < str.len(); i++) begin
            e = {i == str.len() - 1, 8'(str[i])};
            if (s) q1.push_back(e); else q0.push_back(e);
        end
    endtask

    task automatic push_rand(input bit s);
        int n;
        logic [8:0] e;
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) begin
            e = {i == n - 1, al[$urandom_range(0, 3)]};
            if (s) q1.push_back(e); else q0.push_back(e);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        a0 = s0_valid && s0_ready;
        a1 = s1_valid && s1_ready;
        if (res_valid && res_ready && rnd_hold) hold = $urandom_range(0, 3);
        rv_cnt = (res_valid && !res_ready) ? rv_cnt + 1 : 0;
        @(posedge clk);
        #1;
        if (a0) begin void'(q0.pop_front()); acc_n++; g0 = rnd_gap ? $urandom_range(0, 2) : gap; end
        else if (g0 > 0) g0--;
        if (a1) begin void'(q1.pop_front()); acc_n++; g1 = rnd_gap ? $urandom_range(0, 2) : gap; end
        else if (g1 > 0) g1--;
        s0_valid = q0.size() > 0 && g0 == 0;
        s0_data = q0.size() > 0 ? q0[0][7:0] : 8'($urandom);
        s0_last = q0.size() > 0 && q0[0][8];
        s1_valid = q1.size() > 0 && g1 == 0;
        s1_data = q1.size() > 0 ? q1[0][7:0] : 8'($urandom);
        s1_last = q1.size() > 0 && q1[0][8];
        res_ready = res_valid && rv_cnt >= hold;
    endtask

    task automatic wait_res(input int n);
        for (int k = 0; k < 3000 && got.size() < n; k++) cyc();
        chk("result_count", got.size(), n);
    endtask

    task automatic chk_res(input int i, input logic s, input logic h, input int o, input int ln);
        res_t r;
        r = i < got.size() ? got[i] : '1;
        chk("lit_src", r.src, s);
        chk("lit_hit", r.hit, h);
        chk("lit_offset", r.off, o);
        chk("lit_len", r.len, ln);
    endtask

    task automatic chk_zero();
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        chk("rst_nfa_en", nfa_en, 0);
        chk("rst_nfa_clear", nfa_clear, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_hit", res_hit, 0);
        chk("rst_nfa_payload", nfa_payload, 0);
        chk("rst_res_offset", res_offset, 0);
        chk("rst_res_len", res_len, 0);
        chk("rst_res_src", res_src, 0);
    endtask

    task automatic apply_reset();
        #2 reset_n = 0;
        q0.delete(); q1.delete();
        s0_valid = 0; s1_valid = 0; res_ready = 0;
        g0 = 0; g1 = 0; rv_cnt = 0;
        #1 chk_zero();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    initial begin
        apply_reset();
        // first match offset and single clear pulse
        push(0, "xabcy");
        wait_res(1);
        repeat (4) cyc();
        chk_res(0, 0, 1, 3, 5);
        chk("clear_pulses", clr_cnt, 1);
        // no hit, then a lone "c" must not complete the previous "ab"
        push(1, "ab");
        wait_res(2);
        push(0, "c");
        wait_res(3);
        chk_res(1, 1, 0, 0, 2);
        chk_res(2, 0, 0, 0, 1);
        // both requesters busy from reset: strict alternation starting with s0
        apply_reset();
        for (int i = 0; i < 3; i++) begin push_rand(0); push_rand(1); end
        n0 = got.size();
        wait_res(n0 + 6);
        for (int i = 0; i < 6; i++) chk("rr_order", (n0 + i < got.size()) ? got[n0 + i].src : 1'bx, i % 2);
        // result held back for 6 cycles
        hold = 6;
        n0 = got.size();
        push(1, "zzabc");
        wait_res(n0 + 1);
        repeat (8) cyc();
        chk("one_result", got.size(), n0 + 1);
        chk_res(n0, 1, 1, 4, 5);
        hold = 0;
        // valid gaps inside a packet
        gap = 2;
        n0 = got.size();
        push(0, "abcabc");
        wait_res(n0 + 1);
        chk_res(n0, 0, 1, 2, 6);
        gap = 0;
        // reset in the middle of a packet drops it
        n0 = got.size();
        push(0, "abxq");
        a0 = 0;
        for (int k = 0, s = acc_n; k < 100 && acc_n < s + 2; k++) cyc();
        apply_reset();
        repeat (10) cyc();
        chk("dropped_packet", got.size(), n0);
        push(0, "abc");
        wait_res(n0 + 1);
        chk_res(n0, 0, 1, 2, 3);
        // random traffic, gaps and back-pressure
        rnd_gap = 1;
        rnd_hold = 1;
        n0 = got.size();
        for (int i = 0; i < 40; i++) push_rand($urandom_range(0, 1));
        for (int k = 0; k < 6000 && (q0.size() > 0 || q1.size() > 0 || phase != 0); k++) cyc();
        repeat (5) cyc();
        chk("random_drained", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nfa_stream_sched.md
# nfa_stream_sched

Packet-level scheduler that shares one byte-serial NFA matcher (the `repeat_nfa_top` `en`/`payload`/`match` datapath) between two byte-stream requesters.
- Arbitrates round-robin per packet and feeds the granted packet's bytes to the NFA.
- Waits out the NFA match latency, then reports hit, first-match offset and length per packet on a valid/ready result port.
- Clears NFA state before the next packet.
- Sits between the ingress byte streams and the matcher instance.

## Interface
- `LEN_W`, 16: width of byte counters and of `res_offset`/`res_len`.
- `MATCH_LAT`, 1: cycles from a byte being presented on `nfa_payload` with `nfa_en`=1 to its `nfa_match` being valid.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s0_valid` / `s1_valid`  in  1  requester byte valid.
- `s0_data` / `s1_data`  in  8  requester byte.
- `s0_last` / `s1_last`  in  1  byte is the final byte of the packet.
- `s0_ready` / `s1_ready`  out  1  byte accepted when valid&&ready.
- `nfa_en`  out  1  registered; NFA advances only on cycles with `nfa_en`=1.
- `nfa_payload`  out  8  registered byte to NFA.
- `nfa_clear`  out  1  registered one-cycle synchronous NFA state clear.
- `nfa_match`  in  1  NFA match flag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when valid&&ready.
- `res_src`  out  1  requester of the reported packet.
- `res_hit`  out  1  at least one match in the packet.
- `res_offset`  out  LEN_W  0-based index of the byte that produced the first match; 0 if no hit.
- `res_len`  out  LEN_W  bytes accepted in the packet, saturating at 2^LEN_W-1.

## Operation
- FSM states: IDLE, STREAM, DRAIN, REPORT, CLEAR.
- IDLE:
  - Any `sX_valid` → grant and go to STREAM.
  - Both valid → grant the source not granted last.
  - Single valid → grant that source.
  - `last_grant` resets to 1, so s0 wins the first tie.
- STREAM:
  - `sX_ready` = 1 only for the granted source; the other ready is 0.
  - Each accepted byte registers into `nfa_payload` with `nfa_en`=1 on the next cycle.
  - Cycles with no accept drive `nfa_en`=0; `nfa_payload` holds.
  - Byte index increments per accept.
  - Acceptance of a byte with `sX_last`=1 → DRAIN; ready drops in the same cycle the FSM leaves STREAM.
- Match tracking:
  - Delay (`nfa_en`, index) by MATCH_LAT.
  - When the delayed en=1 and `nfa_match`=1 and no hit yet: set hit and capture offset.
  - `nfa_match` while delayed en=0 is ignored.
  - Later matches do not change the offset.
- DRAIN: lasts exactly 1+MATCH_LAT cycles so the last byte's match is sampled, then → REPORT.
- REPORT:
  - `res_valid`=1; `res_src`, `res_hit`, `res_offset`, `res_len` stable until handshake.
  - No source readys, `nfa_en`=0.
  - On `res_ready` → CLEAR.
- CLEAR: `nfa_clear`=1 for exactly one cycle; counters and hit flag zeroed; → IDLE.
- Saturation: `res_len` saturates at 2^LEN_W-1; the index used for offset capture saturates identically.

## Timing
- Reset values (async, immediate):
  - `s0_ready`, `s1_ready`, `nfa_en`, `nfa_clear`, `res_valid`, `res_hit` = 0.
  - `nfa_payload`, `res_offset`, `res_len`, `res_src` = 0.
  - State IDLE; `last_grant` = 1.
- Reset mid-packet: the packet is dropped, no result is issued, and NFA state is left to the NFA's own reset. The requester must restart the packet.
- Arbitration: one IDLE cycle. Ready is first high the cycle after valid is seen in IDLE.
- Byte throughput: 1 byte/cycle in STREAM.
- Byte accepted at edge k → on NFA ports during cycle k+1 → match sampled at edge k+1+MATCH_LAT.
- Per-packet overhead after the last accept: 1+MATCH_LAT (DRAIN) + ≥1 (REPORT) + 1 (CLEAR) + 1 (IDLE) cycles.
- Zero-length packets do not exist; the first accepted byte may carry last.
- Results are issued strictly in grant order; only one packet is in flight.

## Test plan
Bench uses a behavioural NFA model matching "abc" with MATCH_LAT=1 and honouring `nfa_en`/`nfa_clear`.
- s0 sends "xabcy" (0x78,0x61,0x62,0x63,0x79), last on 0x79 → `res_src`=0, `res_hit`=1, `res_offset`=3, `res_len`=5. `nfa_clear` pulses once after the handshake.
- s1 sends "ab" → `res_src`=1, `res_hit`=0, `res_offset`=0, `res_len`=2. The next s0 packet "c" yields hit=0, proving clear.
- Both valid from reset with 3 queued packets each → grant order s0,s1,s0,s1,s0,s1; the non-granted ready is never 1.
- `res_ready` held low 6 cycles in REPORT → `res_valid` and its fields stable, `s0_ready`=`s1_ready`=`nfa_en`=0, then exactly one result.
- s0 sends "abcabc" with `s0_valid` gaps of 2 cycles → `nfa_en` low in the gaps, `res_offset`=2, `res_len`=6.
- `reset_n` pulsed low after 2 bytes of a packet → all outputs 0 immediately, no `res_valid`. The next full "abc" packet gives hit=1, offset=2, len=3.
